// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the FIFO blocks.
//   fifoDepth()   : number of rows addressed by a pointer of a given width
//   fifoCountW()  : width of an occupancy counter that must hold 0..DEPTH
//   FIFO_*        : default pointer width, almost-flag levels, count width
//   fifoOp_e      : which of write/read were accepted in a cycle
// ---------------------------------------------------------------------------
package fifo_pkg;

   // Rows addressed by an addrW-bit pointer
   function automatic int fifoDepth(input int addrW);
      return 1 << addrW;
   endfunction

   // Occupancy needs one extra bit so that a completely full FIFO is representable
   function automatic int fifoCountW(input int addrW);
      return addrW + 1;
   endfunction

   localparam int FIFO_ADDR_W   = 5;
   localparam int FIFO_DEPTH    = fifoDepth(FIFO_ADDR_W);
   localparam int FIFO_AF_LEVEL = FIFO_DEPTH - 4;
   localparam int FIFO_AE_LEVEL = 4;
   localparam int FIFO_COUNT_W  = fifoCountW(FIFO_ADDR_W);

   // Encoded as {write accepted, read accepted}
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_BOTH  = 2'b11
   } fifoOp_e;

endpackage

// File: rtl/onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
// N-to-2^N one-hot decoder with enable; used for the FIFO word lines.
//   sel_i  : N-bit row index
//   en_i   : when low, every output line is low
//   line_o : 2^N one-hot row lines
// ---------------------------------------------------------------------------
module onehot_decoder
   import fifo_pkg::*;
#(
   parameter int N = FIFO_ADDR_W
) (
   input  logic [N-1:0]            sel_i,
   input  logic                    en_i,
   output logic [fifoDepth(N)-1:0] line_o
);

   // Only the selected row is raised, and only while enabled, so at most one
   // line is ever high.
   always_comb begin
      line_o = '0;
      if (en_i) begin
         line_o[sel_i] = 1'b1;
      end
   end

endmodule

// File: rtl/fifo_wordline_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wordline_ctrl
// Pointer / word-line controller for the structural FIFO RAM.
// Holds write and read pointers, occupancy and status flags, and decodes the
// pointers into one-hot row write enables and a row read select.
//
// Optional feature macro: FIFO_WL_ALMOST_EN adds AF_LEVEL/AE_LEVEL parameters
// and registered AlmostFull_o / AlmostEmpty_o outputs.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   Clear_i       : synchronous flush, wins over requests
//   WrReq_i       : write request
//   RdReq_i       : read request
//   WrLine_o      : one-hot row write enable (only on an accepted write)
//   RdLine_o      : one-hot row read select (whenever data is held)
//   WrAddr_o      : write pointer
//   RdAddr_o      : read pointer
//   Count_o       : occupancy 0..DEPTH
//   Full_o        : Count == DEPTH
//   Empty_o       : Count == 0
//   Overflow_o    : sticky, a write was refused while full
//   Underflow_o   : sticky, a read was refused while empty
//   AlmostFull_o  : Count >= AF_LEVEL (macro only)
//   AlmostEmpty_o : Count <= AE_LEVEL (macro only)
// ---------------------------------------------------------------------------
module fifo_wordline_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W = FIFO_ADDR_W
`ifdef FIFO_WL_ALMOST_EN
   ,
   parameter int AF_LEVEL = fifoDepth(ADDR_W) - 4,
   parameter int AE_LEVEL = FIFO_AE_LEVEL
`endif
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          Clear_i,
   input  logic                          WrReq_i,
   input  logic                          RdReq_i,
   output logic [fifoDepth(ADDR_W)-1:0]  WrLine_o,
   output logic [fifoDepth(ADDR_W)-1:0]  RdLine_o,
   output logic [ADDR_W-1:0]             WrAddr_o,
   output logic [ADDR_W-1:0]             RdAddr_o,
   output logic [fifoCountW(ADDR_W)-1:0] Count_o,
   output logic                          Full_o,
   output logic                          Empty_o,
   output logic                          Overflow_o,
`ifdef FIFO_WL_ALMOST_EN
   output logic                          AlmostFull_o,
   output logic                          AlmostEmpty_o,
`endif
   output logic                          Underflow_o
);

   localparam int                DEPTH     = fifoDepth(ADDR_W);
   localparam int                CNT_W     = fifoCountW(ADDR_W);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, empty_q;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wrAcc, rdAcc;
   fifoOp_e           op;

   // Acceptance looks only at registered flags, so a simultaneous read on a
   // full FIFO still refuses the write in that cycle (and vice versa when
   // empty). Pointers wrap naturally because they are exactly ADDR_W wide.
   always_comb begin
      wrAcc       = WrReq_i & ~full_q & ~Clear_i;
      rdAcc       = RdReq_i & ~empty_q & ~Clear_i;
      op          = fifoOp_e'({wrAcc, rdAcc});
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (WrReq_i & full_q);
      underflow_d = underflow_q | (RdReq_i & empty_q);
      if (Clear_i) begin
         wrPtr_d     = '0;
         rdPtr_d     = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wrAcc) wrPtr_d = wrPtr_q + ADDR_W'(1);
         if (rdAcc) rdPtr_d = rdPtr_q + ADDR_W'(1);
         case (op)
            OP_WRITE: count_d = count_q + CNT_W'(1);
            OP_READ:  count_d = count_q - CNT_W'(1);
            default:  count_d = count_q;
         endcase
      end
   end

   // Flags are computed from the next count so they line up with Count_o
   // one cycle after the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         full_q      <= (count_d == DEPTH_CNT);
         empty_q     <= (count_d == '0);
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef FIFO_WL_ALMOST_EN
   logic almostFull_q, almostEmpty_q;

   // Threshold flags follow the same next-count timing as Full/Empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         almostFull_q  <= 1'b0;
         almostEmpty_q <= 1'b1;
      end else begin
         almostFull_q  <= (count_d >= CNT_W'(AF_LEVEL));
         almostEmpty_q <= (count_d <= CNT_W'(AE_LEVEL));
      end
   end

   assign AlmostFull_o  = almostFull_q;
   assign AlmostEmpty_o = almostEmpty_q;
`endif

   // The write row fires on the same edge the pointer advances; the read row
   // marks the head entry as valid whether or not a read is requested.
   onehot_decoder #(.N(ADDR_W)) uWrDec (
      .sel_i  (wrPtr_q),
      .en_i   (wrAcc),
      .line_o (WrLine_o)
   );

   onehot_decoder #(.N(ADDR_W)) uRdDec (
      .sel_i  (rdPtr_q),
      .en_i   (~empty_q),
      .line_o (RdLine_o)
   );

   assign WrAddr_o    = wrPtr_q;
   assign RdAddr_o    = rdPtr_q;
   assign Count_o     = count_q;
   assign Full_o      = full_q;
   assign Empty_o     = empty_q;
   assign Overflow_o  = overflow_q;
   assign Underflow_o = underflow_q;

endmodule

// File: tb/tb_fifo_wordline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_wordline_ctrl
// Self-checking bench for fifo_wordline_ctrl (default ADDR_W = 5, 32 rows).
// A plain integer model (count, two modulo-32 pointers, two sticky bits)
// predicts every output. Define FIFO_WL_ALMOST_EN to also check the
// almost-full / almost-empty flags.
// ---------------------------------------------------------------------------
module tb_fifo_wordline_ctrl;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Clear_i = 1'b0;
   logic        WrReq_i = 1'b0;
   logic        RdReq_i = 1'b0;
   logic [31:0] WrLine_o, RdLine_o;
   logic [4:0]  WrAddr_o, RdAddr_o;
   logic [5:0]  Count_o;
   logic        Full_o, Empty_o, Overflow_o, Underflow_o;
`ifdef FIFO_WL_ALMOST_EN
   logic        AlmostFull_o, AlmostEmpty_o;
`endif

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   int mCount, mWr, mRd;
   bit mOvf, mUnf;

   // Values captured just before each edge
   logic [31:0] preWrLine, preRdLine, expWrLine, expRdLine;
   logic [4:0]  preWrAddr;

   fifo_wordline_ctrl #(.ADDR_W(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .Clear_i       (Clear_i),
      .WrReq_i       (WrReq_i),
      .RdReq_i       (RdReq_i),
      .WrLine_o      (WrLine_o),
      .RdLine_o      (RdLine_o),
      .WrAddr_o      (WrAddr_o),
      .RdAddr_o      (RdAddr_o),
      .Count_o       (Count_o),
      .Full_o        (Full_o),
      .Empty_o       (Empty_o),
      .Overflow_o    (Overflow_o),
`ifdef FIFO_WL_ALMOST_EN
      .AlmostFull_o  (AlmostFull_o),
      .AlmostEmpty_o (AlmostEmpty_o),
`endif
      .Underflow_o   (Underflow_o)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   // Return the model to its power-on state
   task automatic resetModel();
      mCount = 0;
      mWr    = 0;
      mRd    = 0;
      mOvf   = 0;
      mUnf   = 0;
   endtask

   // Drive one cycle of requests (called at posedge+1), capture the word
   // lines before the edge along with the model's prediction, then advance
   // the model past the edge. Returns at the following posedge+1.
   task automatic applyStimulus(input bit wr, input bit rd, input bit clr);
      bit wa, ra;
      WrReq_i = wr;
      RdReq_i = rd;
      Clear_i = clr;
      #1;
      preWrLine = WrLine_o;
      preRdLine = RdLine_o;
      preWrAddr = WrAddr_o;
      wa = wr && !clr && (mCount < DEPTH);
      ra = rd && !clr && (mCount > 0);
      expWrLine = wa ? (32'd1 << mWr) : 32'd0;
      expRdLine = (mCount > 0) ? (32'd1 << mRd) : 32'd0;
      @(posedge clk);
      #1;
      if (clr) begin
         resetModel();
      end else begin
         if (wr && !wa) mOvf = 1;
         if (rd && !ra) mUnf = 1;
         if (wa) mWr = (mWr + 1) % DEPTH;
         if (ra) mRd = (mRd + 1) % DEPTH;
         mCount = mCount + int'(wa) - int'(ra);
      end
   endtask

   task automatic test_reset();
      // Values held right after power-on reset
      checks++; if (Count_o !== 6'd0)  begin failures++; $display("[TB] FAIL rst_count got %0d exp 0", Count_o); end
      checks++; if (Empty_o !== 1'b1)  begin failures++; $display("[TB] FAIL rst_empty got %b exp 1", Empty_o); end
      checks++; if (Full_o !== 1'b0)   begin failures++; $display("[TB] FAIL rst_full got %b exp 0", Full_o); end
      checks++; if (RdLine_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_rdline got %h exp 0", RdLine_o); end
      // Build up Count=7, then pull reset between edges
      for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0);
      checks++; if (Count_o !== 6'd7) begin failures++; $display("[TB] FAIL rst_pre_count got %0d exp 7", Count_o); end
      WrReq_i = 0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (Count_o !== 6'd0)   begin failures++; $display("[TB] FAIL rst_async_count got %0d exp 0", Count_o); end
      checks++; if (WrAddr_o !== 5'd0)  begin failures++; $display("[TB] FAIL rst_async_wraddr got %0d exp 0", WrAddr_o); end
      checks++; if (RdAddr_o !== 5'd0)  begin failures++; $display("[TB] FAIL rst_async_rdaddr got %0d exp 0", RdAddr_o); end
      checks++; if (Empty_o !== 1'b1)   begin failures++; $display("[TB] FAIL rst_async_empty got %b exp 1", Empty_o); end
      checks++; if (RdLine_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_async_rdline got %h exp 0", RdLine_o); end
      checks++; if (WrLine_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_async_wrline got %h exp 0", WrLine_o); end
      checks++; if (Overflow_o !== 1'b0 || Underflow_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_sticky got %b%b exp 00", Overflow_o, Underflow_o); end
`ifdef FIFO_WL_ALMOST_EN
      checks++; if (AlmostFull_o !== 1'b0 || AlmostEmpty_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_async_almost got %b%b exp 01", AlmostFull_o, AlmostEmpty_o); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      resetModel();
   endtask

   task automatic test_fill();
      applyStimulus(0, 0, 1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, 0, 0);
         checks++; if (preWrLine !== (32'd1 << i)) begin failures++; $display("[TB] FAIL fill_wrline[%0d] got %h exp %h", i, preWrLine, 32'd1 << i); end
      end
      checks++; if (Full_o !== 1'b1)    begin failures++; $display("[TB] FAIL fill_full got %b exp 1", Full_o); end
      checks++; if (Count_o !== 6'd32)  begin failures++; $display("[TB] FAIL fill_count got %0d exp 32", Count_o); end
      applyStimulus(1, 0, 0);
      checks++; if (preWrLine !== 32'd0) begin failures++; $display("[TB] FAIL fill_33_wrline got %h exp 0", preWrLine); end
      checks++; if (Count_o !== 6'd32)   begin failures++; $display("[TB] FAIL fill_33_count got %0d exp 32", Count_o); end
      checks++; if (Overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL fill_33_overflow got %b exp 1", Overflow_o); end
   endtask

   task automatic test_wrap();
      int expA [4] = '{30, 31, 0, 1};
      applyStimulus(0, 0, 1);
      for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0);
      for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 0);
         checks++; if (preWrAddr !== 5'(expA[i])) begin failures++; $display("[TB] FAIL wrap_addr[%0d] got %0d exp %0d", i, preWrAddr, expA[i]); end
         checks++; if (preWrLine !== (32'd1 << expA[i])) begin failures++; $display("[TB] FAIL wrap_line[%0d] got %h exp %h", i, preWrLine, 32'd1 << expA[i]); end
      end
      checks++; if (Count_o !== 6'd4) begin failures++; $display("[TB] FAIL wrap_count got %0d exp 4", Count_o); end
   endtask

   task automatic test_simultaneous();
      applyStimulus(0, 0, 1);
      applyStimulus(1, 1, 0);
      checks++; if (Count_o !== 6'd1)     begin failures++; $display("[TB] FAIL simul_empty_count got %0d exp 1", Count_o); end
      checks++; if (Underflow_o !== 1'b1) begin failures++; $display("[TB] FAIL simul_empty_underflow got %b exp 1", Underflow_o); end
      for (int i = 0; i < 31; i++) applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      checks++; if (Count_o !== 6'd31)   begin failures++; $display("[TB] FAIL simul_full_count got %0d exp 31", Count_o); end
      checks++; if (Overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL simul_full_overflow got %b exp 1", Overflow_o); end
      for (int i = 0; i < 21; i++) applyStimulus(0, 1, 0);
      applyStimulus(1, 1, 0);
      checks++; if (Count_o !== 6'd10) begin failures++; $display("[TB] FAIL simul_mid_count got %0d exp 10", Count_o); end
   endtask

   task automatic test_clear();
      applyStimulus(0, 0, 1);
      applyStimulus(0, 1, 0);
      for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0);
      checks++; if (Count_o !== 6'd12 || Underflow_o !== 1'b1) begin failures++; $display("[TB] FAIL clear_pre got cnt=%0d unf=%b exp cnt=12 unf=1", Count_o, Underflow_o); end
      applyStimulus(1, 0, 1);
      WrReq_i = 0;
      Clear_i = 0;
      #1;
      checks++; if (preWrLine !== 32'd0) begin failures++; $display("[TB] FAIL clear_wrline_pre got %h exp 0", preWrLine); end
      checks++; if (Count_o !== 6'd0)    begin failures++; $display("[TB] FAIL clear_count got %0d exp 0", Count_o); end
      checks++; if (Empty_o !== 1'b1)    begin failures++; $display("[TB] FAIL clear_empty got %b exp 1", Empty_o); end
      checks++; if (WrAddr_o !== 5'd0 || RdAddr_o !== 5'd0) begin failures++; $display("[TB] FAIL clear_ptrs got %0d/%0d exp 0/0", WrAddr_o, RdAddr_o); end
      checks++; if (WrLine_o !== 32'd0)  begin failures++; $display("[TB] FAIL clear_wrline got %h exp 0", WrLine_o); end
      checks++; if (Overflow_o !== 1'b0 || Underflow_o !== 1'b0) begin failures++; $display("[TB] FAIL clear_sticky got %b%b exp 00", Overflow_o, Underflow_o); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      bit wr, rd, clr;
      int pWr;
      applyStimulus(0, 0, 1);
      for (int c = 0; c < 600; c++) begin
         // Alternate write-heavy and read-heavy phases to visit full and empty
         pWr = ((c / 60) % 2 == 0) ? 80 : 25;
         wr  = $urandom_range(99) < pWr;
         rd  = $urandom_range(99) < (100 - pWr);
         clr = $urandom_range(199) == 0;
         applyStimulus(wr, rd, clr);
         checks++; if (preWrLine !== expWrLine) begin failures++; $display("[TB] FAIL rnd_wrline c=%0d got %h exp %h", c, preWrLine, expWrLine); end
         checks++; if (preRdLine !== expRdLine) begin failures++; $display("[TB] FAIL rnd_rdline c=%0d got %h exp %h", c, preRdLine, expRdLine); end
         checks++; if (Count_o !== 6'(mCount))  begin failures++; $display("[TB] FAIL rnd_count c=%0d got %0d exp %0d", c, Count_o, mCount); end
         checks++; if (Full_o !== (mCount == DEPTH) || Empty_o !== (mCount == 0)) begin failures++; $display("[TB] FAIL rnd_flags c=%0d got f=%b e=%b exp cnt=%0d", c, Full_o, Empty_o, mCount); end
         checks++; if (WrAddr_o !== 5'(mWr) || RdAddr_o !== 5'(mRd)) begin failures++; $display("[TB] FAIL rnd_ptrs c=%0d got %0d/%0d exp %0d/%0d", c, WrAddr_o, RdAddr_o, mWr, mRd); end
         checks++; if (Overflow_o !== mOvf || Underflow_o !== mUnf) begin failures++; $display("[TB] FAIL rnd_sticky c=%0d got %b%b exp %b%b", c, Overflow_o, Underflow_o, mOvf, mUnf); end
`ifdef FIFO_WL_ALMOST_EN
         checks++; if (AlmostFull_o !== (mCount >= 28) || AlmostEmpty_o !== (mCount <= 4)) begin failures++; $display("[TB] FAIL rnd_almost c=%0d got %b%b cnt=%0d", c, AlmostFull_o, AlmostEmpty_o, mCount); end
`endif
      end
   endtask

`ifdef FIFO_WL_ALMOST_EN
   task automatic test_almost();
      applyStimulus(0, 0, 1);
      for (int i = 1; i <= 28; i++) begin
         applyStimulus(1, 0, 0);
         checks++; if (AlmostFull_o !== (i >= 28)) begin failures++; $display("[TB] FAIL almost_full cnt=%0d got %b exp %b", i, AlmostFull_o, i >= 28); end
      end
      for (int i = 27; i >= 4; i--) begin
         applyStimulus(0, 1, 0);
         checks++; if (AlmostEmpty_o !== (i <= 4)) begin failures++; $display("[TB] FAIL almost_empty cnt=%0d got %b exp %b", i, AlmostEmpty_o, i <= 4); end
      end
   endtask
`endif

   initial begin
      resetModel();
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_wrap();
      test_simultaneous();
      test_clear();
`ifdef FIFO_WL_ALMOST_EN
      test_almost();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
